// File: rtl/aes256_key_expansion.sv
// AES-256 key schedule: accepts one 256-bit key and expands it into
// the 15 round keys rk0..rk14, one 128-bit round key per clock.
module aes256_key_expansion (
    input  logic          clk,
    input  logic          resetn,
    input  logic [255:0]  key_in_tdata,
    input  logic          key_in_tvalid,
    output logic          key_in_tready,
    output logic [1919:0] round_keys,
    output logic          round_keys_valid,
    output logic          busy
);

    localparam int NUM_ROUND_KEYS = 15;
    localparam logic [3:0] LAST_RK = 4'd14;

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_cnt;
    logic         r_valid;
    logic [127:0] r_rk [NUM_ROUND_KEYS];

    logic         w_hs;
    logic [3:0]   w_ia;
    logic [3:0]   w_ip;
    logic [127:0] w_a;
    logic [31:0]  w_p;
    logic [31:0]  w_rot;
    logic [31:0]  w_t;
    logic [7:0]   w_rcon;
    logic [31:0]  w_w0;
    logic [31:0]  w_w1;
    logic [31:0]  w_w2;
    logic [31:0]  w_w3;
    logic [127:0] w_new;

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (zero maps to zero), then the affine transform
    function automatic logic [7:0] s_box_f(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {s_box_f(w[31:24]), s_box_f(w[23:16]),
                s_box_f(w[15:8]),  s_box_f(w[7:0])};
    endfunction

    assign w_hs = key_in_tvalid & key_in_tready;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_hs) w_state_nxt = EXPAND;
            EXPAND:  if (r_cnt == LAST_RK) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Indices are clamped so idle counts never address past the array
    always_comb begin
        w_ia   = (r_cnt >= 4'd2) ? r_cnt - 4'd2 : 4'd0;
        w_ip   = (r_cnt >= 4'd1) ? r_cnt - 4'd1 : 4'd0;
        w_a    = r_rk[w_ia];
        w_p    = r_rk[w_ip][127:96];
        w_rot  = {w_p[7:0], w_p[31:8]};
        w_rcon = 8'h01 << (r_cnt[3:1] - 3'd1);
        if (!r_cnt[0]) w_t = sub_word(w_rot) ^ {24'h0, w_rcon};
        else           w_t = sub_word(w_p);
        w_w0  = w_a[31:0]   ^ w_t;
        w_w1  = w_a[63:32]  ^ w_w0;
        w_w2  = w_a[95:64]  ^ w_w1;
        w_w3  = w_a[127:96] ^ w_w2;
        w_new = {w_w3, w_w2, w_w1, w_w0};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt   <= 4'd0;
            r_valid <= 1'b0;
            for (int i = 0; i < NUM_ROUND_KEYS; i++) r_rk[i] <= '0;
        end else if (w_hs) begin
            r_rk[0] <= key_in_tdata[127:0];
            r_rk[1] <= key_in_tdata[255:128];
            r_cnt   <= 4'd2;
            r_valid <= 1'b0;
        end else if (r_state == EXPAND) begin
            r_rk[r_cnt] <= w_new;
            r_cnt       <= r_cnt + 4'd1;
            if (r_cnt == LAST_RK) r_valid <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_ROUND_KEYS; g++) begin : g_pack
        assign round_keys[128*g +: 128] = r_rk[g];
    end

    assign key_in_tready    = (r_state == IDLE);
    assign busy             = (r_state == EXPAND);
    assign round_keys_valid = r_valid;

endmodule
